// File: rtl/pdm_word_packer_pkg.sv
// Shared constants and FSM encoding for the PDM word packer.
// Imported by the packer top so the state encoding has one definition.
package pdm_word_packer_pkg;

   localparam int unsigned DEF_DW       = 32;
   localparam int unsigned DEF_AW       = 16;
   localparam logic [15:0] WORD_CNT_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

endpackage

// File: rtl/pdm_word_packer_sync_chain.sv
// Single-bit flop-chain synchronizer with asynchronous active-high reset.
// Depth is a parameter (at least 2) so the chain can be reused for other async pins.
module sync_chain #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ff <= '0;
      else     ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/pdm_word_packer.sv
// Packs the synchronized PDM bit stream into DW-bit words and writes them to the capture BRAM.
// Also reports the ones count of the last written word and a saturating count of words written.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | no word in progress; first rw_d cycle accepts a bit, enters FILL
//   ST_FILL  | shifting bits in; full word written on the DW-th bit
//   ST_FLUSH | one cycle: write zero-padded partial word, return to IDLE
module pdm_word_packer
   import pdm_word_packer_pkg::*;
#(
   parameter int unsigned DW          = DEF_DW,
   parameter int unsigned AW          = DEF_AW,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pdm_din,
   input  logic                 rw,
   input  logic [AW-1:0]        didx,
   input  logic                 clr,
   output logic                 mem_we,
   output logic [AW-1:0]        mem_addr,
   output logic [DW-1:0]        mem_wdata,
   output logic [$clog2(DW):0]  ones_cnt,
   output logic [15:0]          word_cnt,
   output logic                 partial
);

   localparam int unsigned BW = $clog2(DW);
   localparam int unsigned CW = BW + 1;

   function automatic logic [CW-1:0] popcount(input logic [DW-1:0] w);
      logic [CW-1:0] n;
      n = '0;
      for (int i = 0; i < DW; i++) n = n + CW'(w[i]);
      return n;
   endfunction

   logic                   pdm_s;
   logic [SYNC_STAGES-1:0] rw_pipe;
   logic [AW-1:0]          didx_pipe [SYNC_STAGES];
   logic                   rw_d;
   logic [AW-1:0]          didx_d;

   state_e                 state, state_nxt;
   logic [DW-1:0]          shreg, shreg_nxt, shreg_in;
   logic [BW-1:0]          bcnt, bcnt_nxt;
   logic [BW:0]            pad;

   logic                   wr, wr_partial, wr_ok;
   logic [DW-1:0]          wr_data;
   logic [AW-1:0]          wr_addr;
   logic [15:0]            word_cnt_q;

   sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (pdm_din),
      .q   (pdm_s)
   );

   // rw/didx are delayed by the synchronizer depth so each strobe pairs with its own pin sample
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rw_pipe <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) didx_pipe[i] <= '0;
      end else if (clr) begin
         rw_pipe <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) didx_pipe[i] <= '0;
      end else begin
         rw_pipe      <= {rw_pipe[SYNC_STAGES-2:0], rw};
         didx_pipe[0] <= didx;
         for (int i = 1; i < SYNC_STAGES; i++) didx_pipe[i] <= didx_pipe[i-1];
      end
   end

   assign rw_d     = rw_pipe[SYNC_STAGES-1];
   assign didx_d   = didx_pipe[SYNC_STAGES-1];
   assign shreg_in = {shreg[DW-2:0], pdm_s};
   assign pad      = (BW+1)'(DW) - {1'b0, bcnt};

   always_comb begin
      state_nxt  = state;
      shreg_nxt  = shreg;
      bcnt_nxt   = bcnt;
      wr         = 1'b0;
      wr_partial = 1'b0;
      wr_data    = shreg_in;
      wr_addr    = didx_d;
      unique case (state)
         ST_IDLE: begin
            if (rw_d) begin
               shreg_nxt = shreg_in;
               bcnt_nxt  = BW'(1);
               state_nxt = ST_FILL;
            end
         end
         ST_FILL: begin
            if (rw_d) begin
               shreg_nxt = shreg_in;
               bcnt_nxt  = bcnt + BW'(1);
               if (bcnt == BW'(DW-1)) wr = 1'b1;
            end else if (bcnt == '0) begin
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            // the bcnt newest bits sit in the LSBs; shifting aligns the first one to the MSB
            wr         = 1'b1;
            wr_partial = 1'b1;
            wr_data    = shreg << pad;
            bcnt_nxt   = '0;
            state_nxt  = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         shreg <= '0;
         bcnt  <= '0;
      end else if (clr) begin
         state <= ST_IDLE;
         shreg <= '0;
         bcnt  <= '0;
      end else begin
         state <= state_nxt;
         shreg <= shreg_nxt;
         bcnt  <= bcnt_nxt;
      end
   end

   assign wr_ok = wr & ~clr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_we     <= 1'b0;
         partial    <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         ones_cnt   <= '0;
         word_cnt_q <= '0;
      end else begin
         mem_we  <= wr_ok;
         partial <= wr_ok & wr_partial;
         if (wr_ok) begin
            mem_addr  <= wr_addr;
            mem_wdata <= wr_data;
            ones_cnt  <= popcount(wr_data);
         end
         if (clr)
            word_cnt_q <= '0;
         else if (wr && word_cnt_q != WORD_CNT_MAX)
            word_cnt_q <= word_cnt_q + 16'd1;
      end
   end

   assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_pdm_word_packer.sv
// Self-checking bench for pdm_word_packer: directed scenarios plus randomized bursts
// checked against a bit-list reference model of the packing rules.
module tb_pdm_word_packer;

   localparam int DW = 32;
   localparam int AW = 16;
   localparam int SS = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pdm_din = 1'b0;
   logic          rw = 1'b0;
   logic [AW-1:0] didx = '0;
   logic          clr = 1'b0;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [5:0]    ones_cnt;
   logic [15:0]   word_cnt;
   logic          partial;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int stray_partial = 0;
   int burst_start = 0;

   logic [DW-1:0] act_data[$];
   logic [AW-1:0] act_addr[$];
   int            act_ones[$];
   logic          act_part[$];
   logic [15:0]   act_wcnt[$];
   int            act_cyc[$];

   logic [DW-1:0] exp_data[$];
   logic [AW-1:0] exp_addr[$];
   int            exp_ones[$];
   logic          exp_part[$];
   logic [15:0]   exp_wcnt[$];
   int            exp_cyc[$];

   int            bits[$];
   logic [15:0]   m_wcnt = '0;

   pdm_word_packer #(.DW(DW), .AW(AW), .SYNC_STAGES(SS)) dut (
      .clk       (clk),
      .rst       (rst),
      .pdm_din   (pdm_din),
      .rw        (rw),
      .didx      (didx),
      .clr       (clr),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .ones_cnt  (ones_cnt),
      .word_cnt  (word_cnt),
      .partial   (partial)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (mem_we) begin
            act_data.push_back(mem_wdata);
            act_addr.push_back(mem_addr);
            act_ones.push_back(int'(ones_cnt));
            act_part.push_back(partial);
            act_wcnt.push_back(word_cnt);
            act_cyc.push_back(cyc);
         end
         if (partial && !mem_we) stray_partial++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: accepted bits are listed in order; first bit is the word MSB, missing bits are zero.
   task automatic model_emit(input logic [AW-1:0] a, input logic part, input int c);
      logic [DW-1:0] w;
      int ones;
      w = '0;
      ones = 0;
      for (int j = 0; j < bits.size(); j++) begin
         w[DW-1-j] = (bits[j] != 0);
         ones += (bits[j] != 0) ? 1 : 0;
      end
      if (m_wcnt != 16'hFFFF) m_wcnt = m_wcnt + 16'd1;
      exp_data.push_back(w);
      exp_addr.push_back(a);
      exp_ones.push_back(ones);
      exp_part.push_back(part);
      exp_wcnt.push_back(m_wcnt);
      exp_cyc.push_back(c);
      bits.delete();
   endtask

   task automatic clear_logs();
      act_data.delete(); act_addr.delete(); act_ones.delete();
      act_part.delete(); act_wcnt.delete(); act_cyc.delete();
      exp_data.delete(); exp_addr.delete(); exp_ones.delete();
      exp_part.delete(); exp_wcnt.delete(); exp_cyc.delete();
      stray_partial = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rw = 1'b0;
         pdm_din = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      rw = 1'b0;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      m_wcnt = '0;
      bits.delete();
      idle(2);
   endtask

   // mode: 0 random, 1 ones, 2 zeros, 3 pattern 1,0,1,1; amode: 0 fixed, 1 base+i, 2 random
   task automatic drive_burst(input int len, input int mode, input int amode,
                              input logic [AW-1:0] base, input logic [AW-1:0] tail);
      for (int i = 0; i < len; i++) begin
         int b;
         logic [AW-1:0] a;
         @(negedge clk);
         if (i == 0) burst_start = cyc;
         case (mode)
            0:       b = int'($urandom_range(0, 1));
            1:       b = 1;
            2:       b = 0;
            default: b = (i % 4 != 1) ? 1 : 0;
         endcase
         case (amode)
            0:       a = base;
            1:       a = base + AW'(i);
            default: a = AW'($urandom);
         endcase
         pdm_din = (b != 0);
         rw = 1'b1;
         didx = a;
         bits.push_back(b);
         if (bits.size() == DW) model_emit(a, 1'b0, cyc + SS + 1);
      end
      @(negedge clk);
      rw = 1'b0;
      didx = tail;
      pdm_din = 1'($urandom_range(0, 1));
      if (bits.size() > 0) model_emit(tail, 1'b1, -1);
      idle(SS + 6);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({mem_we, partial, mem_addr, mem_wdata, ones_cnt, word_cnt} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got we=%b p=%b a=%h d=%h o=%0d w=%h, required all zero",
                  mem_we, partial, mem_addr, mem_wdata, ones_cnt, word_cnt);
      end
      rst = 1'b0;
      for (int i = 0; i < DW + 12; i++) begin
         @(negedge clk);
         rw = 1'b1;
         pdm_din = 1'b1;
         didx = 16'h0007;
      end
      n_cmp++;
      if (word_cnt !== 16'd1 || mem_wdata !== 32'hFFFFFFFF) begin
         n_err++;
         $display("FAIL reset_prefill: got word_cnt=%h data=%h, required 0001 ffffffff", word_cnt, mem_wdata);
      end
      @(negedge clk);
      rst = 1'b1;
      rw = 1'b0;
      #1;
      n_cmp++;
      if ({mem_we, partial, mem_addr, mem_wdata, ones_cnt, word_cnt} !== '0) begin
         n_err++;
         $display("FAIL reset_midword: got we=%b p=%b a=%h d=%h o=%0d w=%h, required all zero",
                  mem_we, partial, mem_addr, mem_wdata, ones_cnt, word_cnt);
      end
      clear_logs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle(2 * DW + 8);
      n_cmp++;
      if (act_data.size() != 0 || word_cnt !== 16'd0) begin
         n_err++;
         $display("FAIL reset_release: got %0d writes word_cnt=%h, required 0 writes 0000",
                  act_data.size(), word_cnt);
      end
   endtask

   task automatic test_single_word();
      pulse_clr();
      clear_logs();
      drive_burst(DW, 3, 0, 16'h0005, 16'h0005);
      n_cmp++;
      if (act_data.size() != 1) begin
         n_err++;
         $display("FAIL single_count: got %0d writes, required 1", act_data.size());
      end else begin
         n_cmp++;
         if (act_data[0] !== 32'hBBBBBBBB || act_addr[0] !== 16'h0005) begin
            n_err++;
            $display("FAIL single_word: got data=%h addr=%h, required bbbbbbbb 0005", act_data[0], act_addr[0]);
         end
         n_cmp++;
         if (act_ones[0] != 24 || act_wcnt[0] !== 16'd1 || act_part[0] !== 1'b0) begin
            n_err++;
            $display("FAIL single_status: got ones=%0d wcnt=%h partial=%b, required 24 0001 0",
                     act_ones[0], act_wcnt[0], act_part[0]);
         end
         n_cmp++;
         if (act_cyc[0] != burst_start + DW + SS) begin
            n_err++;
            $display("FAIL single_latency: got cycle %0d, required %0d", act_cyc[0], burst_start + DW + SS);
         end
      end
   endtask

   task automatic test_back_to_back();
      pulse_clr();
      clear_logs();
      drive_burst(3 * DW, 1, 1, 16'h0100, 16'h0200);
      n_cmp++;
      if (act_data.size() != 3) begin
         n_err++;
         $display("FAIL b2b_count: got %0d writes, required 3", act_data.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (act_data[k] !== 32'hFFFFFFFF || act_ones[k] != 32 || act_part[k] !== 1'b0) begin
               n_err++;
               $display("FAIL b2b_word[%0d]: got data=%h ones=%0d partial=%b, required ffffffff 32 0",
                        k, act_data[k], act_ones[k], act_part[k]);
            end
            n_cmp++;
            if (act_addr[k] !== 16'h0100 + AW'(DW * k + DW - 1) || act_wcnt[k] !== 16'(k + 1)) begin
               n_err++;
               $display("FAIL b2b_addr[%0d]: got addr=%h wcnt=%h, required %h %0d",
                        k, act_addr[k], act_wcnt[k], 16'h0100 + AW'(DW * k + DW - 1), k + 1);
            end
            n_cmp++;
            if (act_cyc[k] != burst_start + DW * (k + 1) + SS) begin
               n_err++;
               $display("FAIL b2b_timing[%0d]: got cycle %0d, required %0d",
                        k, act_cyc[k], burst_start + DW * (k + 1) + SS);
            end
         end
      end
      n_cmp++;
      if (word_cnt !== 16'd3) begin
         n_err++;
         $display("FAIL b2b_word_cnt: got %h, required 0003", word_cnt);
      end
   endtask

   task automatic test_partial_flush();
      pulse_clr();
      clear_logs();
      drive_burst(5, 1, 0, 16'h0040, 16'h0040);
      n_cmp++;
      if (act_data.size() != 1) begin
         n_err++;
         $display("FAIL flush_count: got %0d writes, required 1", act_data.size());
      end else begin
         n_cmp++;
         if (act_data[0] !== 32'hF8000000 || act_part[0] !== 1'b1 || act_ones[0] != 5) begin
            n_err++;
            $display("FAIL flush_word: got data=%h partial=%b ones=%0d, required f8000000 1 5",
                     act_data[0], act_part[0], act_ones[0]);
         end
         n_cmp++;
         if (act_addr[0] !== 16'h0040 || act_wcnt[0] !== 16'd1) begin
            n_err++;
            $display("FAIL flush_addr: got addr=%h wcnt=%h, required 0040 0001", act_addr[0], act_wcnt[0]);
         end
      end
      n_cmp++;
      if (stray_partial != 0) begin
         n_err++;
         $display("FAIL flush_pulse: got %0d partial cycles without mem_we, required 0", stray_partial);
      end
   endtask

   task automatic test_clear_mid_word();
      pulse_clr();
      clear_logs();
      // 20 bits reach the FSM; two more are still in the delay pipe when clr hits
      for (int i = 0; i < 20 + SS; i++) begin
         @(negedge clk);
         rw = 1'b1;
         pdm_din = 1'b1;
         didx = 16'h0030;
      end
      @(negedge clk);
      rw = 1'b0;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      idle(DW + 8);
      n_cmp++;
      if (act_data.size() != 0 || word_cnt !== 16'd0) begin
         n_err++;
         $display("FAIL clear_discard: got %0d writes word_cnt=%h, required 0 writes 0000",
                  act_data.size(), word_cnt);
      end
      clear_logs();
      m_wcnt = '0;
      bits.delete();
      drive_burst(DW, 2, 0, 16'h0031, 16'h0031);
      n_cmp++;
      if (act_data.size() != 1) begin
         n_err++;
         $display("FAIL clear_next_count: got %0d writes, required 1", act_data.size());
      end else begin
         n_cmp++;
         if (act_data[0] !== 32'h0 || act_ones[0] != 0 || act_wcnt[0] !== 16'd1 || act_addr[0] !== 16'h0031) begin
            n_err++;
            $display("FAIL clear_next_word: got data=%h ones=%0d wcnt=%h addr=%h, required 00000000 0 0001 0031",
                     act_data[0], act_ones[0], act_wcnt[0], act_addr[0]);
         end
      end
   endtask

   task automatic test_saturation();
      pulse_clr();
      clear_logs();
      @(negedge clk);
      force dut.word_cnt_q = 16'hFFFE;
      @(negedge clk);
      release dut.word_cnt_q;
      @(negedge clk);
      n_cmp++;
      if (word_cnt !== 16'hFFFE) begin
         n_err++;
         $display("FAIL sat_preload: got %h, required fffe", word_cnt);
      end
      m_wcnt = 16'hFFFE;
      drive_burst(3 * DW, 0, 2, '0, 16'h0077);
      n_cmp++;
      if (act_data.size() != 3) begin
         n_err++;
         $display("FAIL sat_count: got %0d writes, required 3", act_data.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (act_wcnt[k] !== 16'hFFFF || act_data[k] !== exp_data[k] || act_addr[k] !== exp_addr[k]) begin
               n_err++;
               $display("FAIL sat_word[%0d]: got wcnt=%h data=%h addr=%h, required ffff %h %h",
                        k, act_wcnt[k], act_data[k], act_addr[k], exp_data[k], exp_addr[k]);
            end
         end
      end
      n_cmp++;
      if (word_cnt !== 16'hFFFF) begin
         n_err++;
         $display("FAIL sat_hold: got %h, required ffff", word_cnt);
      end
   endtask

   task automatic test_random();
      int n;
      pulse_clr();
      clear_logs();
      for (int b = 0; b < 16; b++) begin
         int len;
         len = (b % 5 == 0) ? DW * int'($urandom_range(1, 2)) : int'($urandom_range(1, 100));
         drive_burst(len, 0, 2, '0, AW'($urandom));
      end
      n_cmp++;
      if (act_data.size() != exp_data.size()) begin
         n_err++;
         $display("FAIL rand_count: got %0d writes, required %0d", act_data.size(), exp_data.size());
      end
      n = (act_data.size() < exp_data.size()) ? act_data.size() : exp_data.size();
      for (int k = 0; k < n; k++) begin
         n_cmp++;
         if (act_data[k] !== exp_data[k] || act_addr[k] !== exp_addr[k]) begin
            n_err++;
            $display("FAIL rand_word[%0d]: got data=%h addr=%h, required %h %h",
                     k, act_data[k], act_addr[k], exp_data[k], exp_addr[k]);
         end
         n_cmp++;
         if (act_ones[k] != exp_ones[k] || act_part[k] !== exp_part[k] || act_wcnt[k] !== exp_wcnt[k]) begin
            n_err++;
            $display("FAIL rand_status[%0d]: got ones=%0d partial=%b wcnt=%h, required %0d %b %h",
                     k, act_ones[k], act_part[k], act_wcnt[k], exp_ones[k], exp_part[k], exp_wcnt[k]);
         end
         if (exp_cyc[k] >= 0) begin
            n_cmp++;
            if (act_cyc[k] != exp_cyc[k]) begin
               n_err++;
               $display("FAIL rand_timing[%0d]: got cycle %0d, required %0d", k, act_cyc[k], exp_cyc[k]);
            end
         end
      end
      n_cmp++;
      if (stray_partial != 0) begin
         n_err++;
         $display("FAIL rand_pulse: got %0d partial cycles without mem_we, required 0", stray_partial);
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_partial_flush();
      test_clear_mid_word();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
